// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the j1soc reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STAGE,
        ST_RUN
    } state_e;

    localparam int DEF_N_CH        = 3;
    localparam int DEF_HOLD_CYCLES = 20;
    localparam int DEF_STAGE_GAP   = 8;
    localparam int DEF_SW_PULSE    = 16;
    localparam int DEF_CNT_W       = 16;

    // Width of an index that must also hold the "all released" value n.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clock edge.
module rst_sync (
    input  logic clk_i,
    input  logic arst_i,
    output logic rst_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking so sync_q[1] takes last cycle's sync_q[0]; blocking would collapse both stages into one.
            sync_q[0] <= 1'b0;
            sync_q[1] <= sync_q[0];
        end
    end

    assign rst_o = sync_q[1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: hold, release channels in order, then serve software and global reset requests.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int SW_PULSE    = DEF_SW_PULSE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [N_CH-1:0] sw_rst_i,
    input  logic            glb_req_i,
    output logic [N_CH-1:0] rst_o,
    output logic            ready_o
);

    localparam int IDX_W = idx_width(N_CH);

    // After power-on the first hold edge already counts; after a global request an extra edge is spent.
    localparam logic [CNT_W-1:0] HOLD_LD_POR = (HOLD_CYCLES >= 2) ? CNT_W'(HOLD_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] HOLD_LD_GLB = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD      = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] PULSE_LD    = CNT_W'(SW_PULSE - 1);
    localparam logic [IDX_W-1:0] ALL_DONE    = IDX_W'(N_CH);

    logic            rst_int;
    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic            hold_armed_q;
    logic            hold_ext_q;
    logic [N_CH-1:0] rst_q;
    logic            ready_q;
    logic            run;
    logic [N_CH-1:0] pulse_load;
    logic [N_CH-1:0] pulse_end;

    rst_sync u_rst_sync (
        .clk_i  (sys_clk_i),
        .arst_i (sys_rst_i),
        .rst_o  (rst_int)
    );

    assign run = (state_q == ST_RUN);

    for (genvar k = 0; k < N_CH; k++) begin : g_pulse
        logic [CNT_W-1:0] pcnt_q;

        always_ff @(posedge sys_clk_i or posedge rst_int) begin
            if (rst_int) begin
                pcnt_q <= '0;
            end else if (glb_req_i) begin
                pcnt_q <= '0;
            end else if (pulse_load[k]) begin
                pcnt_q <= PULSE_LD;
            end else if (run && (pcnt_q != '0)) begin
                pcnt_q <= pcnt_q - CNT_W'(1);
            end
        end

        assign pulse_load[k] = run && !glb_req_i && sw_rst_i[k];
        assign pulse_end[k]  = run && !glb_req_i && !sw_rst_i[k] && rst_q[k] && (pcnt_q == '0);
    end

    always_ff @(posedge sys_clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            hold_armed_q <= 1'b0;
            hold_ext_q   <= 1'b0;
            rst_q        <= '1;
            ready_q      <= 1'b0;
        end else if (glb_req_i) begin
            // Global request beats any software request and restarts the whole sequence.
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            hold_armed_q <= 1'b0;
            hold_ext_q   <= 1'b1;
            rst_q        <= '1;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (!hold_armed_q && !(!hold_ext_q && (HOLD_CYCLES == 1))) begin
                        hold_armed_q <= 1'b1;
                        hold_ext_q   <= 1'b0;
                        cnt_q        <= hold_ext_q ? HOLD_LD_GLB : HOLD_LD_POR;
                    end else if (!hold_armed_q || (cnt_q == '0)) begin
                        state_q      <= ST_STAGE;
                        rst_q[0]     <= 1'b0;
                        idx_q        <= IDX_W'(1);
                        cnt_q        <= GAP_LD;
                        hold_armed_q <= 1'b0;
                        hold_ext_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_STAGE: begin
                    if (idx_q == ALL_DONE) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (idx_q == IDX_W'(k)) rst_q[k] <= 1'b0;
                        end
                        idx_q <= idx_q + IDX_W'(1);
                        cnt_q <= GAP_LD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_q   <= (rst_q | pulse_load) & ~pulse_end;
                    ready_q <= ~|rst_q && ~|pulse_load;
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign rst_o   = rst_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a default instance and a minimal N_CH=1 / HOLD=1 / GAP=1 instance.
module tb_rst_seq;

    typedef struct {
        int         cyc;
        bit         dut1;
        logic [2:0] rst;
        logic       rdy;
        string      name;
    } exp_t;

    logic       clk;
    logic       sys_rst0, sys_rst1;
    logic [2:0] sw0;
    logic [0:0] sw1;
    logic       glb0, glb1;
    logic [2:0] rst0;
    logic [0:0] rst1;
    logic       rdy0, rdy1;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   base;
    exp_t exp_q[$];
    exp_t async_q[$];
    event async_ev;

    rst_seq u_dut0 (
        .sys_clk_i (clk),
        .sys_rst_i (sys_rst0),
        .sw_rst_i  (sw0),
        .glb_req_i (glb0),
        .rst_o     (rst0),
        .ready_o   (rdy0)
    );

    rst_seq #(
        .N_CH        (1),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1)
    ) u_dut1 (
        .sys_clk_i (clk),
        .sys_rst_i (sys_rst1),
        .sw_rst_i  (sw1),
        .glb_req_i (glb1),
        .rst_o     (rst1),
        .ready_o   (rdy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got rst,ready=%b required %b", name, act, expv);
        end
    endtask

    task automatic expect_at(input int c, input bit d1, input logic [2:0] r, input logic rdy,
                             input string name);
        exp_t e;
        e.cyc  = c;
        e.dut1 = d1;
        e.rst  = r;
        e.rdy  = rdy;
        e.name = $sformatf("%s@%0d", name, c);
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic sw_pulse(input int t, input logic [2:0] v);
        goto(t - 1);
        sw0 = v;
        goto(t);
        sw0 = '0;
    endtask

    // Monitor: compares outputs sampled on the falling edge against queued expectations.
    always @(negedge clk) begin : mon
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL %s: not sampled, now at edge %0d", e.name, cyc);
            end else if (e.dut1) begin
                check(e.name, {2'b00, rst1, rdy1}, {e.rst, e.rdy});
            end else begin
                check(e.name, {rst0, rdy0}, {e.rst, e.rdy});
            end
        end
    end

    always @(async_ev) begin : mon_async
        exp_t e;
        if (async_q.size() != 0) begin
            e = async_q.pop_front();
            check(e.name, {rst0, rdy0}, {e.rst, e.rdy});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : drive
        exp_t a;
        sys_rst0 = 1'b1;
        sys_rst1 = 1'b1;
        sw0      = '0;
        sw1      = '0;
        glb0     = 1'b0;
        glb1     = 1'b0;

        // Reset state of both instances.
        expect_at(3, 1'b0, 3'b111, 1'b0, "por_in_reset");
        expect_at(5, 1'b1, 3'b001, 1'b0, "c1_in_reset");
        expect_at(8, 1'b0, 3'b111, 1'b0, "por_in_reset");

        // Power-on: spec edge n maps to absolute edge base+n.
        goto(10);
        base = 10;
        expect_at(base + 2,  1'b0, 3'b111, 1'b0, "por_sync");
        expect_at(base + 21, 1'b0, 3'b111, 1'b0, "por_hold_end");
        expect_at(base + 22, 1'b0, 3'b110, 1'b0, "por_ch0");
        expect_at(base + 29, 1'b0, 3'b110, 1'b0, "por_gap");
        expect_at(base + 30, 1'b0, 3'b100, 1'b0, "por_ch1");
        expect_at(base + 37, 1'b0, 3'b100, 1'b0, "por_gap");
        expect_at(base + 38, 1'b0, 3'b000, 1'b0, "por_ch2");
        expect_at(base + 39, 1'b0, 3'b000, 1'b1, "por_ready");
        sys_rst0 = 1'b0;
        // Software requests during HOLD must not disturb the timing above.
        goto(base + 4);
        sw0 = 3'b111;
        goto(base + 8);
        sw0 = '0;

        // Modem software reset.
        expect_at(54, 1'b0, 3'b000, 1'b1, "sw_pre");
        expect_at(55, 1'b0, 3'b100, 1'b0, "sw_start");
        expect_at(70, 1'b0, 3'b100, 1'b0, "sw_last");
        expect_at(71, 1'b0, 3'b000, 1'b0, "sw_clear");
        expect_at(72, 1'b0, 3'b000, 1'b1, "sw_ready");
        sw_pulse(55, 3'b100);

        // Extension on channel 1 overlapping a channel 0 pulse.
        expect_at(79,  1'b0, 3'b000, 1'b1, "ovl_pre");
        expect_at(80,  1'b0, 3'b010, 1'b0, "ovl_ch1");
        expect_at(85,  1'b0, 3'b011, 1'b0, "ovl_both");
        expect_at(100, 1'b0, 3'b011, 1'b0, "ovl_both");
        expect_at(101, 1'b0, 3'b010, 1'b0, "ovl_ch0_end");
        expect_at(105, 1'b0, 3'b010, 1'b0, "ovl_ext");
        expect_at(106, 1'b0, 3'b000, 1'b0, "ovl_ch1_end");
        expect_at(107, 1'b0, 3'b000, 1'b1, "ovl_ready");
        sw_pulse(80, 3'b010);
        sw_pulse(85, 3'b001);
        sw_pulse(90, 3'b010);

        // Global request during a channel-2 pulse, colliding with a software request.
        expect_at(119, 1'b0, 3'b000, 1'b1, "glb_pre");
        expect_at(120, 1'b0, 3'b100, 1'b0, "glb_pulse");
        expect_at(124, 1'b0, 3'b100, 1'b0, "glb_pulse");
        expect_at(125, 1'b0, 3'b111, 1'b0, "glb_all");
        expect_at(145, 1'b0, 3'b111, 1'b0, "glb_hold_end");
        expect_at(146, 1'b0, 3'b110, 1'b0, "glb_ch0");
        expect_at(154, 1'b0, 3'b100, 1'b0, "glb_ch1");
        expect_at(161, 1'b0, 3'b100, 1'b0, "glb_gap");
        expect_at(162, 1'b0, 3'b000, 1'b0, "glb_ch2");
        expect_at(163, 1'b0, 3'b000, 1'b1, "glb_ready");
        expect_at(165, 1'b0, 3'b000, 1'b1, "glb_no_resume");
        sw_pulse(120, 3'b100);
        goto(124);
        sw0  = 3'b011;
        glb0 = 1'b1;
        goto(125);
        sw0  = '0;
        glb0 = 1'b0;

        // Async reset while in STAGE after channel 0 release.
        expect_at(170, 1'b0, 3'b111, 1'b0, "ar_glb");
        expect_at(191, 1'b0, 3'b110, 1'b0, "ar_ch0");
        expect_at(192, 1'b0, 3'b111, 1'b0, "ar_held");
        expect_at(193, 1'b0, 3'b111, 1'b0, "ar_held");
        goto(169);
        glb0 = 1'b1;
        goto(170);
        glb0 = 1'b0;
        goto(191);
        a.cyc  = 191;
        a.dut1 = 1'b0;
        a.rst  = 3'b111;
        a.rdy  = 1'b0;
        a.name = "ar_async";
        async_q.push_back(a);
        #2 sys_rst0 = 1'b1;
        #1 ->async_ev;
        goto(194);
        base = 194;
        expect_at(base + 2,  1'b0, 3'b111, 1'b0, "ar_sync");
        expect_at(base + 21, 1'b0, 3'b111, 1'b0, "ar_hold_end");
        expect_at(base + 22, 1'b0, 3'b110, 1'b0, "ar_ch0");
        expect_at(base + 30, 1'b0, 3'b100, 1'b0, "ar_ch1");
        expect_at(base + 38, 1'b0, 3'b000, 1'b0, "ar_ch2");
        expect_at(base + 39, 1'b0, 3'b000, 1'b1, "ar_ready");
        sys_rst0 = 1'b0;

        // Minimal-parameter instance.
        goto(236);
        base = 240;
        expect_at(base + 2, 1'b1, 3'b001, 1'b0, "c1_sync");
        expect_at(base + 3, 1'b1, 3'b000, 1'b0, "c1_ch0");
        expect_at(base + 4, 1'b1, 3'b000, 1'b1, "c1_ready");
        goto(base);
        sys_rst1 = 1'b0;

        goto(250);
        n_checks++;
        if (exp_q.size() != 0 || async_q.size() != 0) begin
            n_err++;
            $display("FAIL pending: %0d expectations never checked, required 0",
                     exp_q.size() + async_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer for the j1soc platform. It replaces the fixed "hold reset for 20 cycles" behaviour with a synthesizable block that does three things:
- conditions the board reset;
- holds all domains for a programmable time, then releases N_CH reset channels in a staged order (CPU, peripherals, modem);
- accepts per-channel software reset pulses (e.g. modem `mod_rst`) and a global re-sequence request at run time.

## Interface
Parameters:
- `N_CH`, 3: number of reset channels; channel 0 is released first.
- `HOLD_CYCLES`, 20: cycles all channels stay in reset after the synchronised reset deasserts (≥1).
- `STAGE_GAP`, 8: cycles between release of channel k and channel k+1 (≥1).
- `SW_PULSE`, 16: length in cycles of a software-requested channel reset (≥1).
- `CNT_W`, 16: width of the internal counters; must hold max(HOLD_CYCLES, STAGE_GAP, SW_PULSE).

Ports:
- `sys_clk_i`  in  1  system clock; the only clock.
- `sys_rst_i`  in  1  reset, asynchronous, active-high.
- `sw_rst_i`  in  N_CH  per-channel software reset request, sampled on `sys_clk_i`, active-high.
- `glb_req_i`  in  1  global re-sequence request, one-cycle pulse.
- `rst_o`  out  N_CH  channel resets, active-high, registered.
- `ready_o`  out  1  high when every channel is out of reset and the sequencer is in RUN.

## Operation
- **Reset input conditioning.** `sys_rst_i` asserts the internal reset asynchronously. It deasserts synchronously through a 2-flop synchronizer.
- **Outputs during reset.** While `sys_rst_i` is high or the internal reset is active: `rst_o` = all ones, `ready_o` = 0, FSM = HOLD, all counters = 0.
- **FSM states:**
  - HOLD: counts HOLD_CYCLES, then goes to STAGE and releases channel 0.
  - STAGE: releases channel k+1 every STAGE_GAP cycles. After the last channel is released it goes to RUN.
  - RUN: sets `ready_o` = 1.
- **Software reset pulses (RUN only).**
  - `sw_rst_i[k]` high for one or more cycles sets `rst_o[k]`=1 on the next edge and loads that channel's pulse counter with SW_PULSE.
  - `rst_o[k]` clears when the counter expires.
  - A request during an active pulse reloads the counter, so the pulse is extended.
  - Multiple channels may pulse simultaneously and independently.
  - `ready_o` = 0 while any `rst_o` bit is high.
- **`sw_rst_i` outside RUN.** Ignored in HOLD and STAGE.
- **Global request.**
  - `glb_req_i` in RUN or STAGE: `rst_o` = all ones and `ready_o` = 0 on the next edge, FSM → HOLD, and all counters, including pulse counters, are cleared.
  - `glb_req_i` in HOLD: restarts the hold count.
- **Simultaneous requests.** If `glb_req_i` and `sw_rst_i` arrive in the same cycle, `glb_req_i` wins.
- **Reset mid-operation.** `sys_rst_i` asserted in any state forces the reset values asynchronously, within the same cycle.
- **Counter arithmetic.** All counters are unsigned, count down, and saturate at 0. No wrap-around occurs.

## Timing
Edge numbering: edge 1 is the first rising edge of `sys_clk_i` that samples `sys_rst_i` low.
- Synchronised reset deasserts after edge 2.
- `rst_o[0]` falls at edge 2+HOLD_CYCLES.
- `rst_o[k]` falls at edge 2+HOLD_CYCLES+k·STAGE_GAP.
- `ready_o` rises one edge after `rst_o[N_CH-1]` falls.
- Software pulse: request sampled high at edge t gives `rst_o[k]` high over edges t … t+SW_PULSE-1, low at edge t+SW_PULSE. `ready_o` returns high at t+SW_PULSE+1.
- Global request sampled at edge t: `rst_o[0]` falls at t+HOLD_CYCLES+1.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Structure
- **`rst_seq_pkg`:** FSM state enum (HOLD, STAGE, RUN), parameter defaults, and a `clog2`-based width helper.
- **`rst_sync`:** one sub-module for the 2-flop async-assert/sync-deassert synchronizer. It is reused elsewhere for UART domain resets.
- **Top level:** the FSM, the stage counter, the channel index, and N_CH pulse counters in a generate loop.

## Test plan
All scenarios use the defaults (N_CH=3, HOLD=20, GAP=8, PULSE=16) unless noted.
- **Power-on sequence.** `sys_rst_i` high for 10 cycles, then low → `rst_o` = 3'b111 until edge 22. Expected: bit0 low at edge 22, bit1 at edge 30, bit2 at edge 38; `ready_o` high at edge 39.
- **Software modem reset.** In RUN, `sw_rst_i`=3'b100 for 1 cycle at edge t → `rst_o[2]` high over t…t+15; `ready_o` low over t…t+16; `rst_o[1:0]` stay 0.
- **Pulse extension and overlap.** `sw_rst_i[1]` at edge t and again at t+10, plus `sw_rst_i[0]` at t+5 → `rst_o[1]` low at t+26; `rst_o[0]` low at t+21.
- **Global re-sequence.** `glb_req_i` at edge t in RUN with a channel-2 pulse active → `rst_o`=3'b111 at t. Then `rst_o[0]` falls at t+21, `rst_o[2]` at t+37, and the old pulse does not resume.
- **Async reset mid-STAGE.** `sys_rst_i` asserted between edges while channel 0 is released → `rst_o`=3'b111 and `ready_o`=0 before the next edge. Deassertion then repeats the power-on timing.
- **Ignored requests and corner parameters.** `sw_rst_i`=3'b111 during HOLD → no effect on the release timing. Rerun with N_CH=1, HOLD=1, GAP=1 → `rst_o[0]` falls at edge 3 and `ready_o` rises at edge 4.
